// File: rtl/branch_predict_unit.sv
// Fetch-side branch predictor with MEM-stage resolution.
// A direct-mapped BTB with 2-bit saturating counters supplies a 0-cycle
// prediction in IF. The resolver in MEM flags mispredicts, supplies the
// corrected PC, trains the table and keeps branch/miss statistics.
module branch_predict_unit #(
   parameter int IDX_W = 4,
   parameter int TAG_W = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bpin_stall,
   input  logic [31:0] bpin_if_pc,
   output logic        bpout_pred_taken,
   output logic [31:0] bpout_pred_pc,
   input  logic        bpin_mem_valid,
   input  logic [31:0] bpin_mem_pc,
   input  logic        bpin_mem_is_branch_jump,
   input  logic        bpin_mem_taken,
   input  logic [31:0] bpin_mem_target,
   input  logic        bpin_mem_pred_taken,
   input  logic [31:0] bpin_mem_pred_target,
   output logic        bpout_mispredict,
   output logic [31:0] bpout_redirect_pc,
   output logic [31:0] bpout_branch_cnt,
   output logic [31:0] bpout_miss_cnt
);

   localparam int ENTRIES = 1 << IDX_W;

   logic             valid_q  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [31:0]      target_q [ENTRIES];
   logic [1:0]       ctr_q    [ENTRIES];

   logic [31:0] branch_cnt_q, branch_cnt_d;
   logic [31:0] miss_cnt_q, miss_cnt_d;

   logic [IDX_W-1:0] if_idx, mem_idx;
   logic [TAG_W-1:0] if_tag, mem_tag;
   logic             if_hit, mem_hit;
   logic             upd_en;

   logic             wr_en;
   logic             wr_valid;
   logic [TAG_W-1:0] wr_tag;
   logic [31:0]      wr_target;
   logic [1:0]       wr_ctr;

   // IF lookup: purely combinational, reads the registered table contents
   // so a same-cycle MEM write is not visible until the next cycle.
   always_comb begin
      if_idx           = bpin_if_pc[IDX_W+1:2];
      if_tag           = bpin_if_pc[IDX_W+TAG_W+1:IDX_W+2];
      if_hit           = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
      bpout_pred_taken = if_hit && ctr_q[if_idx][1];
      bpout_pred_pc    = bpout_pred_taken ? target_q[if_idx] : (bpin_if_pc + 32'd4);
   end

   // MEM resolution: mispredict and redirect are combinational so they
   // remain meaningful during stall and reset.
   always_comb begin
      mem_idx = bpin_mem_pc[IDX_W+1:2];
      mem_tag = bpin_mem_pc[IDX_W+TAG_W+1:IDX_W+2];
      mem_hit = valid_q[mem_idx] && (tag_q[mem_idx] == mem_tag);
      bpout_mispredict = bpin_mem_valid &&
         ((bpin_mem_is_branch_jump && (bpin_mem_taken != bpin_mem_pred_taken)) ||
          (bpin_mem_is_branch_jump && bpin_mem_taken && bpin_mem_pred_taken &&
           (bpin_mem_target != bpin_mem_pred_target)) ||
          (!bpin_mem_is_branch_jump && bpin_mem_pred_taken));
      bpout_redirect_pc = (bpin_mem_is_branch_jump && bpin_mem_taken) ?
                          bpin_mem_target : (bpin_mem_pc + 32'd4);
   end

   // Training decision: allocate on miss, saturate the counter on hit,
   // drop an entry that predicted taken for a non-branch (alias).
   always_comb begin
      upd_en    = bpin_mem_valid && !bpin_stall;
      wr_en     = 1'b0;
      wr_valid  = valid_q[mem_idx];
      wr_tag    = mem_tag;
      wr_target = target_q[mem_idx];
      wr_ctr    = ctr_q[mem_idx];
      if (upd_en) begin
         if (bpin_mem_is_branch_jump) begin
            wr_en    = 1'b1;
            wr_valid = 1'b1;
            if (!mem_hit) begin
               wr_target = bpin_mem_target;
               wr_ctr    = bpin_mem_taken ? 2'b10 : 2'b01;
            end else if (bpin_mem_taken) begin
               wr_target = bpin_mem_target;
               if (ctr_q[mem_idx] != 2'b11) wr_ctr = ctr_q[mem_idx] + 2'd1;
            end else begin
               if (ctr_q[mem_idx] != 2'b00) wr_ctr = ctr_q[mem_idx] - 2'd1;
            end
         end else if (bpin_mem_pred_taken && mem_hit) begin
            wr_en    = 1'b1;
            wr_valid = 1'b0;
            wr_tag   = tag_q[mem_idx];
         end
      end
   end

   // Statistics counters share the training enable; they wrap naturally.
   always_comb begin
      branch_cnt_d = branch_cnt_q;
      miss_cnt_d   = miss_cnt_q;
      if (upd_en && bpin_mem_is_branch_jump) branch_cnt_d = branch_cnt_q + 32'd1;
      if (upd_en && bpout_mispredict)        miss_cnt_d   = miss_cnt_q + 32'd1;
   end

   // Table and counter state; reset wipes everything and discards any write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= 2'b01;
         end
         branch_cnt_q <= '0;
         miss_cnt_q   <= '0;
      end else begin
         if (wr_en) begin
            valid_q[mem_idx]  <= wr_valid;
            tag_q[mem_idx]    <= wr_tag;
            target_q[mem_idx] <= wr_target;
            ctr_q[mem_idx]    <= wr_ctr;
         end
         branch_cnt_q <= branch_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
      end
   end

   assign bpout_branch_cnt = branch_cnt_q;
   assign bpout_miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit. Stimulus applies inputs just after
// a rising edge and queues the expected outputs for that cycle; a monitor
// drains the queue on the falling edge and compares.
module tb_branch_predict_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        bpin_stall;
   logic [31:0] bpin_if_pc;
   logic        bpout_pred_taken;
   logic [31:0] bpout_pred_pc;
   logic        bpin_mem_valid;
   logic [31:0] bpin_mem_pc;
   logic        bpin_mem_is_branch_jump;
   logic        bpin_mem_taken;
   logic [31:0] bpin_mem_target;
   logic        bpin_mem_pred_taken;
   logic [31:0] bpin_mem_pred_target;
   logic        bpout_mispredict;
   logic [31:0] bpout_redirect_pc;
   logic [31:0] bpout_branch_cnt;
   logic [31:0] bpout_miss_cnt;

   branch_predict_unit dut (
      .clk                     (clk),
      .rst                     (rst),
      .bpin_stall              (bpin_stall),
      .bpin_if_pc              (bpin_if_pc),
      .bpout_pred_taken        (bpout_pred_taken),
      .bpout_pred_pc           (bpout_pred_pc),
      .bpin_mem_valid          (bpin_mem_valid),
      .bpin_mem_pc             (bpin_mem_pc),
      .bpin_mem_is_branch_jump (bpin_mem_is_branch_jump),
      .bpin_mem_taken          (bpin_mem_taken),
      .bpin_mem_target         (bpin_mem_target),
      .bpin_mem_pred_taken     (bpin_mem_pred_taken),
      .bpin_mem_pred_target    (bpin_mem_pred_target),
      .bpout_mispredict        (bpout_mispredict),
      .bpout_redirect_pc       (bpout_redirect_pc),
      .bpout_branch_cnt        (bpout_branch_cnt),
      .bpout_miss_cnt          (bpout_miss_cnt)
   );

   always #5 clk = ~clk;

   typedef enum int {S_PT, S_PPC, S_MIS, S_RED, S_BC, S_MC} sel_t;
   typedef struct {
      string       name;
      sel_t        sel;
      logic [31:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic void expect_out(string n, sel_t s, logic [31:0] v);
      exp_t e;
      e.name = n; e.sel = s; e.val = v;
      sb_q.push_back(e);
   endfunction

   // Monitor: compares every queued expectation against the live outputs.
   initial begin
      forever begin
         @(negedge clk);
         while (sb_q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = sb_q.pop_front();
            case (e.sel)
               S_PT:    act = {31'd0, bpout_pred_taken};
               S_PPC:   act = bpout_pred_pc;
               S_MIS:   act = {31'd0, bpout_mispredict};
               S_RED:   act = bpout_redirect_pc;
               S_BC:    act = bpout_branch_cnt;
               default: act = bpout_miss_cnt;
            endcase
            checks++;
            if (act !== e.val) begin
               errors++;
               $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.val, $time);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(logic [31:0] if_pc);
      bpin_if_pc              = if_pc;
      bpin_stall              = 1'b0;
      bpin_mem_valid          = 1'b0;
      bpin_mem_pc             = 32'h0;
      bpin_mem_is_branch_jump = 1'b0;
      bpin_mem_taken          = 1'b0;
      bpin_mem_target         = 32'h0;
      bpin_mem_pred_taken     = 1'b0;
      bpin_mem_pred_target    = 32'h0;
   endtask

   task automatic mem(logic [31:0] pc, logic bj, logic tk, logic [31:0] tgt,
                      logic ptk, logic [31:0] ptgt);
      bpin_mem_valid          = 1'b1;
      bpin_mem_pc             = pc;
      bpin_mem_is_branch_jump = bj;
      bpin_mem_taken          = tk;
      bpin_mem_target         = tgt;
      bpin_mem_pred_taken     = ptk;
      bpin_mem_pred_target    = ptgt;
   endtask

   task automatic exp_pred(string n, logic pt, logic [31:0] ppc);
      expect_out({n, "_pt"}, S_PT, {31'd0, pt});
      expect_out({n, "_ppc"}, S_PPC, ppc);
   endtask

   task automatic exp_mem(string n, logic mis, logic [31:0] red);
      expect_out({n, "_mis"}, S_MIS, {31'd0, mis});
      expect_out({n, "_red"}, S_RED, red);
   endtask

   task automatic exp_cnt(string n, logic [31:0] bc, logic [31:0] mc);
      expect_out({n, "_bc"}, S_BC, bc);
      expect_out({n, "_mc"}, S_MC, mc);
   endtask

   initial begin
      rst = 1'b1;
      idle(32'h100);
      #1;
      exp_pred("in_reset", 1'b0, 32'h104);
      expect_out("in_reset_mis", S_MIS, 32'd0);
      step(); step();
      rst = 1'b0;

      // Reset state
      step();
      idle(32'h100);
      exp_pred("post_reset", 1'b0, 32'h104);
      expect_out("post_reset_mis", S_MIS, 32'd0);
      exp_cnt("post_reset", 32'd0, 32'd0);

      // First taken branch: allocate with ctr=10
      step();
      mem(32'h100, 1, 1, 32'h200, 0, 32'h0);
      exp_mem("first_bj", 1'b1, 32'h200);
      step();
      idle(32'h100);
      exp_pred("after_alloc", 1'b1, 32'h200);
      exp_cnt("after_alloc", 32'd1, 32'd1);

      // Three correct takens: 10 -> 11 (saturates)
      for (int i = 0; i < 3; i++) begin
         step();
         mem(32'h100, 1, 1, 32'h200, 1, 32'h200);
         expect_out("tk_ok_mis", S_MIS, 32'd0);
      end
      // Not-taken once: 11 -> 10, still taken
      step();
      mem(32'h100, 1, 0, 32'h200, 1, 32'h200);
      exp_mem("nt1", 1'b1, 32'h104);
      step();
      idle(32'h100);
      exp_pred("hyst", 1'b1, 32'h200);
      exp_cnt("hyst", 32'd5, 32'd2);
      // Second not-taken: 10 -> 01
      step();
      mem(32'h100, 1, 0, 32'h200, 1, 32'h200);
      step();
      idle(32'h100);
      exp_pred("nt2", 1'b0, 32'h104);
      exp_cnt("nt2", 32'd6, 32'd3);
      // Ten not-taken, correctly predicted: 01 -> 00, stays 00
      for (int i = 0; i < 10; i++) begin
         step();
         mem(32'h100, 1, 0, 32'h200, 0, 32'h200);
         expect_out("nt_ok_mis", S_MIS, 32'd0);
      end
      step();
      idle(32'h100);
      exp_pred("sat_low", 1'b0, 32'h104);
      exp_cnt("sat_low", 32'd16, 32'd3);
      // One taken from 00 -> 01, still not taken
      step();
      mem(32'h100, 1, 1, 32'h200, 0, 32'h0);
      step();
      idle(32'h100);
      exp_pred("from00", 1'b0, 32'h104);
      // Another taken: 01 -> 10
      step();
      mem(32'h100, 1, 1, 32'h200, 0, 32'h0);
      step();
      idle(32'h100);
      exp_pred("to10", 1'b1, 32'h200);
      exp_cnt("to10", 32'd18, 32'd5);

      // Correct direction, wrong target
      step();
      mem(32'h100, 1, 1, 32'h300, 1, 32'h200);
      exp_mem("bad_tgt", 1'b1, 32'h300);
      step();
      idle(32'h100);
      exp_pred("new_tgt", 1'b1, 32'h300);
      exp_cnt("new_tgt", 32'd19, 32'd6);

      // Alias under stall: no training or count while stalled
      for (int i = 0; i < 3; i++) begin
         step();
         mem(32'h100, 0, 0, 32'h0, 1, 32'h300);
         bpin_stall = 1'b1;
         exp_mem("alias_stall", 1'b1, 32'h104);
         exp_pred("alias_stall", 1'b1, 32'h300);
         exp_cnt("alias_stall", 32'd19, 32'd6);
      end
      step();
      bpin_stall = 1'b0;
      exp_mem("alias_go", 1'b1, 32'h104);
      step();
      idle(32'h100);
      exp_pred("alias_inval", 1'b0, 32'h104);
      exp_cnt("alias_inval", 32'd19, 32'd7);

      // Non-branch, not predicted: no mispredict; invalid MEM ignored
      step();
      mem(32'h180, 0, 0, 32'h0, 0, 32'h0);
      exp_mem("plain", 1'b0, 32'h184);
      step();
      idle(32'h100);
      bpin_mem_pred_taken = 1'b1;
      bpin_mem_is_branch_jump = 1'b1;
      expect_out("nvalid_mis", S_MIS, 32'd0);

      // PC wrap
      step();
      idle(32'hFFFF_FFFC);
      exp_pred("wrap", 1'b0, 32'h0);

      // Same-cycle write/read at index 0: IF sees old contents
      step();
      idle(32'h100);
      mem(32'h100, 1, 1, 32'h400, 0, 32'h0);
      exp_pred("rbw_inv", 1'b0, 32'h104);
      step();
      idle(32'h100);
      mem(32'h100, 1, 1, 32'h500, 1, 32'h400);
      exp_pred("rbw_old", 1'b1, 32'h400);
      exp_mem("rbw_old", 1'b1, 32'h500);
      step();
      idle(32'h100);
      exp_pred("rbw_new", 1'b1, 32'h500);
      exp_cnt("rbw_new", 32'd21, 32'd9);
      // Same index, different tag misses
      step();
      idle(32'h1100);
      exp_pred("tag_miss", 1'b0, 32'h1104);

      // Reset pulse mid-run with a pending write
      step();
      idle(32'h100);
      mem(32'h200, 1, 1, 32'h600, 0, 32'h0);
      rst = 1'b1;
      #1;
      exp_pred("rst_mid", 1'b0, 32'h104);
      exp_mem("rst_mid", 1'b1, 32'h600);
      exp_cnt("rst_mid", 32'd0, 32'd0);
      step();
      rst = 1'b0;
      idle(32'h200);
      exp_pred("rst_drop", 1'b0, 32'h204);
      exp_cnt("rst_drop", 32'd0, 32'd0);

      // Drain the scoreboard with a bounded wait
      begin
         int budget = 20;
         while (sb_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
         end
         if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
         end
      end
      @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
